// File: rtl/instr_fetch_ctrl.sv
// Fetch controller between the PC register and IF/ID: issues imem reads, absorbs wait states, stalls and redirects.
// Optional fetch/bubble performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_CUR,
   output logic [31:0] PC_NEXT,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_RDATA,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   input  logic        JUMP,
   input  logic [31:0] JUMP_TARGET,
   input  logic        EXC,
   output logic [31:0] IF_ID_INSTR,
   output logic [31:0] IF_ID_PC4,
   output logic        IF_ID_VALID,
   output logic [31:0] FETCH_COUNT,
   output logic [31:0] BUBBLE_COUNT
);

   typedef enum logic [1:0] {S_BOOT, S_WAIT, S_HOLD, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_q, skid_d;

   logic        redir;
   logic [31:0] redir_raw, redir_tgt, addr_inc;

   assign redir     = EXC | JUMP | BRANCH_TAKEN;
   assign redir_raw = EXC ? EXC_VECTOR : (JUMP ? JUMP_TARGET : BRANCH_TARGET);
   assign redir_tgt = redir_raw & 32'hFFFF_FFFC;
   assign addr_inc  = addr_q + 32'd4;

   // The PC register reloads every cycle, so the default is to feed PC_CUR back.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      skid_d  = skid_q;
      PC_NEXT = PC_CUR;
      case (state_q)
         S_BOOT: begin
            PC_NEXT = RESET_VECTOR;
            req_d   = 1'b1;
            addr_d  = RESET_VECTOR;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (redir) begin
               PC_NEXT = redir_tgt;
               instr_d = '0;
               pc4_d   = '0;
               valid_d = 1'b0;
               // Without an ACK the read is still in flight and must be drained first.
               if (IMEM_ACK) addr_d = redir_tgt;
               else          state_d = S_DRAIN;
            end else if (IMEM_ACK && !STALL) begin
               instr_d = IMEM_RDATA;
               pc4_d   = addr_inc;
               valid_d = 1'b1;
               PC_NEXT = addr_inc;
               addr_d  = addr_inc;
            end else if (IMEM_ACK) begin
               skid_d  = IMEM_RDATA;
               req_d   = 1'b0;
               state_d = S_HOLD;
            end else if (!STALL) begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (redir) begin
               PC_NEXT = redir_tgt;
               instr_d = '0;
               pc4_d   = '0;
               valid_d = 1'b0;
               addr_d  = redir_tgt;
               req_d   = 1'b1;
               state_d = S_WAIT;
            end else if (!STALL) begin
               instr_d = skid_q;
               pc4_d   = addr_inc;
               valid_d = 1'b1;
               PC_NEXT = addr_inc;
               addr_d  = addr_inc;
               req_d   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_DRAIN: begin
            valid_d = 1'b0;
            if (redir) begin
               PC_NEXT = redir_tgt;
               instr_d = '0;
               pc4_d   = '0;
               if (IMEM_ACK) begin
                  addr_d  = redir_tgt;
                  state_d = S_WAIT;
               end
            end else if (IMEM_ACK) begin
               addr_d  = PC_CUR;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
         req_q   <= 1'b0;
         addr_q  <= '0;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         skid_q  <= skid_d;
      end
   end

   assign IMEM_REQ    = req_q;
   assign IMEM_ADDR   = addr_q;
   assign IF_ID_INSTR = instr_q;
   assign IF_ID_PC4   = pc4_q;
   assign IF_ID_VALID = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;
   logic        ifid_ld;

   // IF/ID is written on every non-boot edge except a stall without redirect in WAIT or HOLD.
   assign ifid_ld = (state_q != S_BOOT) &&
                    !(((state_q == S_WAIT) || (state_q == S_HOLD)) && STALL && !redir);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (ifid_ld && valid_d)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
         if (ifid_ld && !valid_d) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign FETCH_COUNT  = fetch_cnt_q;
   assign BUBBLE_COUNT = bubble_cnt_q;
`else
   assign FETCH_COUNT  = '0;
   assign BUBBLE_COUNT = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: PC register and imem models, scoreboard of words consumed by decode.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] PC_CUR;
   logic [31:0] PC_NEXT;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_ACK;
   logic [31:0] IMEM_RDATA;
   logic        STALL;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic        JUMP;
   logic [31:0] JUMP_TARGET;
   logic        EXC;
   logic [31:0] IF_ID_INSTR;
   logic [31:0] IF_ID_PC4;
   logic        IF_ID_VALID;
   logic [31:0] FETCH_COUNT;
   logic [31:0] BUBBLE_COUNT;

   int          checks = 0;
   int          errors = 0;
   int          mem_delay = 0;
   int          mem_cnt = 0;
   logic [31:0] pc_q = 32'd0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   instr_fetch_ctrl dut (
      .clk(clk), .rst(rst), .PC_CUR(PC_CUR), .PC_NEXT(PC_NEXT),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
      .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
      .JUMP(JUMP), .JUMP_TARGET(JUMP_TARGET), .EXC(EXC),
      .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_PC4(IF_ID_PC4), .IF_ID_VALID(IF_ID_VALID),
      .FETCH_COUNT(FETCH_COUNT), .BUBBLE_COUNT(BUBBLE_COUNT)
   );

   always #5 clk = ~clk;

   // Program counter: loads PC_NEXT on every edge.
   always @(posedge clk) pc_q <= PC_NEXT;
   assign PC_CUR = pc_q;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] perf(input int n);
      logic [31:0] r;
      r = 32'(n);
`ifndef FETCH_PERF_EN
      r = 32'd0;
`endif
      return r;
   endfunction

   // Instruction memory: ACK after mem_delay wait cycles of a raised request.
   initial begin
      IMEM_ACK   = 1'b0;
      IMEM_RDATA = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !IMEM_REQ) begin
            IMEM_ACK = 1'b0;
            mem_cnt  = 0;
         end else if (mem_cnt >= mem_delay) begin
            IMEM_ACK = 1'b1;
            mem_cnt  = 0;
         end else begin
            IMEM_ACK = 1'b0;
            mem_cnt  = mem_cnt + 1;
         end
         IMEM_RDATA = IMEM_ACK ? mem_data(IMEM_ADDR) : 32'hDEAD_BEEF;
      end
   end

   // Decode consumes the IF/ID word in any cycle where it is valid and not stalled.
   always @(negedge clk) begin
      if (!rst && IF_ID_VALID && !STALL) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL sb_extra: got instr=%h pc4=%h, expected no word", IF_ID_INSTR, IF_ID_PC4);
         end else begin
            mon_e = exp_q.pop_front();
            if ({IF_ID_INSTR, IF_ID_PC4} !== mon_e) begin
               errors = errors + 1;
               $display("FAIL sb_word: got instr=%h pc4=%h, expected instr=%h pc4=%h",
                        IF_ID_INSTR, IF_ID_PC4, mon_e[63:32], mon_e[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] a);
      exp_q.push_back({mem_data(a), a + 32'd4});
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_in();
      STALL         = 1'b0;
      EXC           = 1'b0;
      JUMP          = 1'b0;
      BRANCH_TAKEN  = 1'b0;
      JUMP_TARGET   = 32'd0;
      BRANCH_TARGET = 32'd0;
   endtask

   task automatic reset();
      rst = 1'b1;
      clear_in();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req"},    32'(IMEM_REQ), 32'd0);
      check({tag, "_addr"},   IMEM_ADDR, 32'd0);
      check({tag, "_instr"},  IF_ID_INSTR, 32'd0);
      check({tag, "_pc4"},    IF_ID_PC4, 32'd0);
      check({tag, "_valid"},  32'(IF_ID_VALID), 32'd0);
      check({tag, "_fcnt"},   FETCH_COUNT, 32'd0);
      check({tag, "_bcnt"},   BUBBLE_COUNT, 32'd0);
      check({tag, "_pcnext"}, PC_NEXT, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      clear_in();
      step();
      step();
      check_reset_vals("rst0");

      // Zero-wait memory, no stall.
      mem_delay = 0;
      reset();
      push(32'h0); push(32'h4); push(32'h8);
      step();
      check("t1_pc_e1", PC_CUR, 32'h0);
      check("t1_req_e1", 32'(IMEM_REQ), 32'd1);
      check("t1_valid_e1", 32'(IF_ID_VALID), 32'd0);
      step();
      check("t1_valid_e2", 32'(IF_ID_VALID), 32'd1);
      check("t1_pc_e2", PC_CUR, 32'h4);
      step();
      check("t1_pc_e3", PC_CUR, 32'h8);
      step();
      check("t1_pc_e4", PC_CUR, 32'hC);
      check("t1_fcnt", FETCH_COUNT, perf(3));
      check("t1_bcnt", BUBBLE_COUNT, perf(0));
      step();
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // Three wait states per read.
      mem_delay = 3;
      reset();
      push(32'h0); push(32'h4);
      repeat (4) step();
      check("t2_pc_hold", PC_CUR, 32'h0);
      check("t2_addr_hold", IMEM_ADDR, 32'h0);
      check("t2_valid_bub", 32'(IF_ID_VALID), 32'd0);
      check("t2_bcnt_a", BUBBLE_COUNT, perf(3));
      step();
      check("t2_pc4_w0", IF_ID_PC4, 32'h4);
      check("t2_pc_adv", PC_CUR, 32'h4);
      repeat (4) step();
      check("t2_fcnt", FETCH_COUNT, perf(2));
      check("t2_bcnt_b", BUBBLE_COUNT, perf(6));
      step();
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // Stall on the ACK cycle for two cycles.
      mem_delay = 0;
      reset();
      push(32'h0); push(32'h4); push(32'h8);
      step();
      step();
      STALL = 1'b1;
      step();
      check("t3_req_drop", 32'(IMEM_REQ), 32'd0);
      check("t3_pc4_held", IF_ID_PC4, 32'h4);
      step();
      check("t3_pc_held", PC_CUR, 32'h4);
      STALL = 1'b0;
      step();
      check("t3_skid_pc4", IF_ID_PC4, 32'h8);
      step();
      check("t3_pc", PC_CUR, 32'hC);
      check("t3_fcnt", FETCH_COUNT, perf(3));
      step();
      check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // Jump while a read is outstanding.
      mem_delay = 2;
      reset();
      push(32'h100);
      step();
      JUMP = 1'b1;
      JUMP_TARGET = 32'h100;
      step();
      JUMP = 1'b0;
      check("t4_pc_jump", PC_CUR, 32'h100);
      check("t4_valid_flush", 32'(IF_ID_VALID), 32'd0);
      step();
      step();
      check("t4_addr_new", IMEM_ADDR, 32'h100);
      repeat (3) step();
      check("t4_fcnt", FETCH_COUNT, perf(1));
      check("t4_bcnt", BUBBLE_COUNT, perf(5));
      step();
      check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

      // EXC, JUMP and BRANCH together under STALL.
      mem_delay = 0;
      reset();
      push(32'h180);
      step();
      step();
      STALL = 1'b1;
      EXC = 1'b1; JUMP = 1'b1; BRANCH_TAKEN = 1'b1;
      JUMP_TARGET = 32'h200; BRANCH_TARGET = 32'h300;
      #1;
      check("t5_pcnext_exc", PC_NEXT, 32'h180);
      step();
      clear_in();
      check("t5_pc_exc", PC_CUR, 32'h180);
      check("t5_valid_flush", 32'(IF_ID_VALID), 32'd0);
      check("t5_instr_flush", IF_ID_INSTR, 32'd0);
      check("t5_addr_exc", IMEM_ADDR, 32'h180);
      step();
      check("t5_pc4", IF_ID_PC4, 32'h184);
      check("t5_fcnt", FETCH_COUNT, perf(2));
      check("t5_bcnt", BUBBLE_COUNT, perf(1));
      step();
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // Wrap at the top of memory, then reset mid-WAIT.
      reset();
      push(32'hFFFF_FFFC);
      step();
      JUMP = 1'b1;
      JUMP_TARGET = 32'hFFFF_FFFF;
      step();
      JUMP = 1'b0;
      check("t6_pc_top", PC_CUR, 32'hFFFF_FFFC);
      check("t6_addr_top", IMEM_ADDR, 32'hFFFF_FFFC);
      step();
      check("t6_pc_wrap", PC_CUR, 32'h0);
      check("t6_pc4_wrap", IF_ID_PC4, 32'h0);
      check("t6_instr", IF_ID_INSTR, mem_data(32'hFFFF_FFFC));
      step();
      check("t6_req_pre", 32'(IMEM_REQ), 32'd1);
      rst = 1'b1;
      step();
      check_reset_vals("t6_rst");
      check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
